// File: rtl/sender_pkg.sv
// Shared types and constants for the sender channel arbiter.
package sender_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } state_t;

  localparam int DEF_W = 16;  // default data word width
  localparam int TMR_W = 8;   // Ready-edge timeout counter width
  localparam int CNT_W = 4;   // words-per-grant counter width (BURST <= 15)
  localparam int IDX_W = 3;   // source index width (N <= 8)

  // Index of the set bit in a one-hot vector of up to 8 sources.
  function automatic logic [IDX_W-1:0] onehot_idx(input logic [7:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sender_arbiter_rr_pick.sv
// Combinational round-robin picker: first request strictly after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          valid
);

  logic hi_found;
  logic lo_found;

  // Prefer the lowest request above the pointer; otherwise wrap to the lowest overall.
  // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
  always_comb begin
    win      = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!hi_found && req[i] && (i > int'(ptr))) begin
        win[i]   = 1'b1;
        hi_found = 1'b1;
      end
    end
    if (!hi_found) begin
      for (int i = 0; i < N; i++) begin
        if (!lo_found && req[i]) begin
          win[i]   = 1'b1;
          lo_found = 1'b1;
        end
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/sender_arbiter.sv
// Round-robin arbiter sharing one sender handshake channel among N producers.
module sender_arbiter
  import sender_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = DEF_W,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           Reset,
  input  logic [N-1:0]   srcTransmit,
  input  logic [N*W-1:0] srcData,
  output logic [N-1:0]   srcGrant,
  output logic [N-1:0]   srcAccept,
  output logic           sdrTransmit,
  output logic [W-1:0]   sdrDataIn,
  input  logic           sdrReady,
  output logic           busErr,
  output logic [2:0]     errSrc
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    gidx;
  logic [CNT_W-1:0] count;
  logic [TMR_W-1:0] timer;

  logic [N-1:0]     win;
  logic             win_valid;
  logic [PW-1:0]    win_idx;
  logic [W-1:0]     win_data;
  logic [W-1:0]     grant_data;
  logic             expired;
  logic             more;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req   (srcTransmit),
    .ptr   (ptr),
    .win   (win),
    .valid (win_valid)
  );

  // Winner index and the data words of the candidate and the current owner.
  always_comb begin
    win_idx    = PW'(onehot_idx(8'(win)));
    win_data   = srcData[int'(win_idx)*W +: W];
    grant_data = srcData[int'(gidx)*W +: W];
    expired    = (timer <= TMR_W'(1));
    more       = (count < CNT_W'(BURST)) && srcTransmit[gidx];
  end

  // Grant/handshake FSM with registered outputs and Ready-edge watchdog.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      ptr         <= PW'(N - 1);
      gidx        <= '0;
      count       <= '0;
      timer       <= '0;
      srcGrant    <= '0;
      srcAccept   <= '0;
      sdrTransmit <= 1'b0;
      sdrDataIn   <= '0;
      busErr      <= 1'b0;
      errSrc      <= '0;
    end else begin
      srcAccept <= '0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            srcGrant    <= win;
            ptr         <= win_idx;
            gidx        <= win_idx;
            count       <= '0;
            sdrTransmit <= 1'b1;
            sdrDataIn   <= win_data;
            state       <= SEND;
          end
        end
        SEND: begin
          if (sdrReady) begin
            // Word taken this cycle; acceptance wins over a simultaneous withdrawal.
            srcAccept   <= srcGrant;
            count       <= count + CNT_W'(1);
            timer       <= TMR_W'(TIMEOUT);
            sdrTransmit <= 1'b0;
            state       <= WAIT_LO;
          end else if (!srcTransmit[gidx]) begin
            srcGrant    <= '0;
            sdrTransmit <= 1'b0;
            state       <= IDLE;
          end else begin
            sdrDataIn <= grant_data;
          end
        end
        WAIT_LO, WAIT_HI: begin
          if ((state == WAIT_LO) && !sdrReady) begin
            timer <= TMR_W'(TIMEOUT);
            state <= WAIT_HI;
          end else if ((state == WAIT_HI) && sdrReady) begin
            if (more) begin
              sdrTransmit <= 1'b1;
              sdrDataIn   <= grant_data;
              state       <= SEND;
            end else begin
              srcGrant <= '0;
              state    <= IDLE;
            end
          end else if (expired) begin
            // Sender stalled: flag it, remember the first offender, free the channel.
            busErr   <= 1'b1;
            if (!busErr) errSrc <= IDX_W'(gidx);
            srcGrant <= '0;
            timer    <= '0;
            state    <= IDLE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sender_arbiter.sv
// Directed self-checking bench for sender_arbiter with small sender and source models.
module tb_sender_arbiter;

  localparam int N       = 4;
  localparam int W       = 16;
  localparam int BURST   = 2;
  localparam int TIMEOUT = 255;

  logic           clk;
  logic           Reset;
  logic [N-1:0]   srcTransmit;
  logic [N*W-1:0] srcData;
  logic [N-1:0]   srcGrant;
  logic [N-1:0]   srcAccept;
  logic           sdrTransmit;
  logic [W-1:0]   sdrDataIn;
  logic           sdrReady;
  logic           busErr;
  logic [2:0]     errSrc;

  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;

  // Sender model controls.
  logic rdy_hold;
  int   rdy_delay;
  int   rcnt;
  // Source model: words each source still wants to send.
  int   remaining [N];
  // Accept log from the monitor.
  int          acc_src[$];
  logic [W-1:0] acc_data[$];

  sender_arbiter #(.N(N), .W(W), .BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .srcTransmit (srcTransmit),
    .srcData     (srcData),
    .srcGrant    (srcGrant),
    .srcAccept   (srcAccept),
    .sdrTransmit (sdrTransmit),
    .sdrDataIn   (sdrDataIn),
    .sdrReady    (sdrReady),
    .busErr      (busErr),
    .errSrc      (errSrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sender: drop Ready after an accept, raise it again rdy_delay cycles later unless held.
  always @(posedge clk) begin
    #1;
    if (Reset) begin
      if (srcAccept != '0) begin
        sdrReady = 1'b0;
        rcnt = rdy_delay;
      end else if (!rdy_hold && !sdrReady) begin
        if (rcnt > 1) rcnt--;
        else sdrReady = 1'b1;
      end
    end
  end

  // Sources: drop the request once the last wanted word is accepted.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (srcAccept[i] && remaining[i] > 0) begin
        remaining[i]--;
        if (remaining[i] == 0) srcTransmit[i] = 1'b0;
      end
    end
  end

  // Monitor: one-hot invariants and accept log, sampled mid-cycle.
  always @(negedge clk) begin
    if (Reset) begin
      if ($countones(srcGrant) > 1 || $countones(srcAccept) > 1 || (srcAccept & ~srcGrant) != '0)
        viol++;
      for (int i = 0; i < N; i++) begin
        if (srcAccept[i]) begin
          acc_src.push_back(i);
          acc_data.push_back(sdrDataIn);
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_grant"},  32'(srcGrant), 32'h0);
    check({tag, "_accept"}, 32'(srcAccept), 32'h0);
    check({tag, "_tx"},     32'(sdrTransmit), 32'h0);
    check({tag, "_data"},   32'(sdrDataIn), 32'h0);
    check({tag, "_err"},    32'(busErr), 32'h0);
    check({tag, "_errsrc"}, 32'(errSrc), 32'h0);
  endtask

  task automatic do_reset(input bit check_out);
    Reset = 1'b0;
    srcTransmit = '0;
    for (int i = 0; i < N; i++) remaining[i] = 0;
    rdy_hold = 1'b0;
    rdy_delay = 4;
    rcnt = 0;
    sdrReady = 1'b1;
    repeat (2) @(negedge clk);
    if (check_out) check_zero_outputs("reset");
    Reset = 1'b1;
    acc_src.delete();
    acc_data.delete();
  endtask

  task automatic wait_accepts(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (acc_src.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_accepts_seen"}, 32'(acc_src.size() >= n), 32'h1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c;
    c = 0;
    while (srcGrant != '0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_released"}, 32'(srcGrant), 32'h0);
  endtask

  initial begin
    int exp_order [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1, 2, 3};
    int c;
    for (int i = 0; i < N; i++) srcData[i*W +: W] = 16'h1000 + 16'(i);
    Reset = 1'b0;
    srcTransmit = '0;
    sdrReady = 1'b1;
    @(negedge clk);
    do_reset(1'b1);

    // Single source: grant one cycle after request, one accept, then release.
    remaining[0] = 1;
    srcTransmit = 4'b0001;
    @(negedge clk);
    check("single_grant", 32'(srcGrant), 32'h1);
    check("single_tx", 32'(sdrTransmit), 32'h1);
    check("single_data", 32'(sdrDataIn), 32'h1000);
    wait_accepts("single", 1, 20);
    wait_idle("single", 20);
    repeat (5) @(negedge clk);
    check("single_count", 32'(acc_src.size()), 32'h1);
    if (acc_src.size() > 0) check("single_src", 32'(acc_src[0]), 32'h0);

    // Contention: all four request, two bursts per round, strict rotation.
    do_reset(1'b0);
    for (int i = 0; i < N; i++) remaining[i] = 3;
    srcTransmit = 4'b1111;
    wait_accepts("contend", 12, 600);
    wait_idle("contend", 40);
    check("contend_count", 32'(acc_src.size()), 32'd12);
    for (int k = 0; k < 12; k++) begin
      if (k < acc_src.size()) begin
        check($sformatf("contend_src%0d", k), 32'(acc_src[k]), 32'(exp_order[k]));
        check($sformatf("contend_data%0d", k), 32'(acc_data[k]), 32'h1000 + 32'(exp_order[k]));
      end
    end

    // Burst cut short: src2 leaves after one word, src3 is served next.
    do_reset(1'b0);
    remaining[2] = 1;
    remaining[3] = 1;
    srcTransmit = 4'b1100;
    @(negedge clk);
    check("cut_first_grant", 32'(srcGrant), 32'h4);
    wait_accepts("cut", 2, 60);
    if (acc_src.size() >= 2) begin
      check("cut_src0", 32'(acc_src[0]), 32'h2);
      check("cut_src1", 32'(acc_src[1]), 32'h3);
    end

    // Withdrawal: Ready held low, src1 drops in SEND.
    do_reset(1'b0);
    rdy_hold = 1'b1;
    sdrReady = 1'b0;
    remaining[1] = 1;
    srcTransmit = 4'b0010;
    @(negedge clk);
    check("wd_grant", 32'(srcGrant), 32'h2);
    @(negedge clk);
    check("wd_tx_held", 32'(sdrTransmit), 32'h1);
    srcTransmit = 4'b0000;
    @(negedge clk);
    check("wd_grant_clear", 32'(srcGrant), 32'h0);
    check("wd_tx_clear", 32'(sdrTransmit), 32'h0);
    repeat (4) @(negedge clk);
    check("wd_no_accept", 32'(acc_src.size()), 32'h0);

    // Timeout: Ready never returns after src3's word.
    do_reset(1'b0);
    rdy_hold = 1'b1;
    remaining[3] = 1;
    srcTransmit = 4'b1000;
    wait_accepts("tmo", 1, 20);
    c = 0;
    while (!busErr && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("tmo_err", 32'(busErr), 32'h1);
    check("tmo_latency_window", 32'(c >= 250 && c <= 260), 32'h1);
    check("tmo_errsrc", 32'(errSrc), 32'h3);
    check("tmo_grant_clear", 32'(srcGrant), 32'h0);
    rdy_hold = 1'b0;
    remaining[0] = 1;
    srcTransmit = 4'b0001;
    wait_accepts("tmo_after", 2, 60);
    if (acc_src.size() >= 2) check("tmo_after_src", 32'(acc_src[1]), 32'h0);
    check("tmo_err_sticky", 32'(busErr), 32'h1);
    check("tmo_errsrc_sticky", 32'(errSrc), 32'h3);

    // Async reset while waiting for Ready to return.
    do_reset(1'b0);
    rdy_delay = 20;
    remaining[1] = 5;
    srcTransmit = 4'b0010;
    wait_accepts("arst", 1, 20);
    repeat (2) @(negedge clk);
    check("arst_pre_grant", 32'(srcGrant), 32'h2);
    #2 Reset = 1'b0;
    #1 check_zero_outputs("arst");
    @(negedge clk);
    sdrReady = 1'b1;
    rdy_delay = 4;
    rcnt = 0;
    for (int i = 0; i < N; i++) remaining[i] = 1;
    srcTransmit = 4'b1111;
    Reset = 1'b1;
    @(negedge clk);
    check("arst_first_winner", 32'(srcGrant), 32'h1);
    repeat (40) @(negedge clk);

    check("onehot_violations", 32'(viol), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
